// File: rtl/bmp_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bmp_frame_streamer                                                         |
// | Captures one RGB888 frame, then streams it out as a 24-bit BMP byte file.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bmp_frame_streamer #(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int PIX_PER_CLK = 1,
    parameter int HDR_BYTES   = 54
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [24*PIX_PER_CLK-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic                      out_last,
    output logic                      frame_done,
    output logic                      sof_restart
);

    localparam int          c_ROW_BYTES  = 4 * ((3 * WIDTH + 3) / 4);
    localparam int          c_PAD        = c_ROW_BYTES - 3 * WIDTH;
    localparam logic [31:0] c_IMG_BYTES  = 32'(c_ROW_BYTES * HEIGHT);
    localparam logic [31:0] c_FILE_BYTES = 32'(HDR_BYTES + c_ROW_BYTES * HEIGHT);
    localparam int          c_NPIX       = WIDTH * HEIGHT;
    localparam int          c_NWORDS     = c_NPIX / PIX_PER_CLK;
    localparam int          c_AW         = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam int          c_IW         = $clog2(c_NPIX + 1);
    localparam int          c_SHIFT      = (PIX_PER_CLK == 2) ? 1 : 0;
    localparam int          c_DW         = 24 * PIX_PER_CLK;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_CAPTURE = 3'd1;
    localparam logic [2:0] c_S_HEADER  = 3'd2;
    localparam logic [2:0] c_S_PIXELS  = 3'd3;
    localparam logic [2:0] c_S_PAD     = 3'd4;
    localparam logic [2:0] c_S_DONE    = 3'd5;

    logic [2:0]      r_state, w_next_state;
    logic            r_alive, r_sof_restart, r_end;
    logic [c_AW-1:0] r_wr_addr, w_wr_addr, w_rd_addr;
    logic [c_DW-1:0] r_mem [c_NWORDS];
    logic [c_DW-1:0] r_rd_data;
    logic [23:0]     w_cur_pix, r_pix;
    logic [5:0]      r_hdr_idx;
    logic [c_IW-1:0] r_row_base, r_col, w_rd_idx;
    logic [1:0]      r_comp, r_pad_cnt;
    logic            r_out_valid, r_out_last;
    logic [7:0]      r_out_data, w_byte;
    logic            w_accept, w_store, w_cap_last, w_emit, w_load, w_last, w_fire_last;
    logic            w_row_end, w_bottom, w_pad_end, w_rd_en;

    // Header bytes 2..53 are 4-byte little-endian words starting at offset 2.
    function automatic logic [7:0] f_hdr_byte(input logic [5:0] idx);
        logic [5:0]  off;
        logic [31:0] word;
        off = idx - 6'd2;
        case (off[5:2])
            4'd0:    word = c_FILE_BYTES;
            4'd2:    word = 32'(HDR_BYTES);
            4'd3:    word = 32'd40;
            4'd4:    word = 32'(WIDTH);
            4'd5:    word = 32'(HEIGHT);
            4'd6:    word = {16'd24, 16'd1};
            4'd8:    word = c_IMG_BYTES;
            default: word = 32'd0;
        endcase
        if (idx == 6'd0) return 8'h42;
        if (idx == 6'd1) return 8'h4D;
        return word[{off[1:0], 3'b000} +: 8];
    endfunction

    assign w_accept    = in_valid & in_ready;
    assign w_store     = w_accept & (in_sof | (r_state == c_S_CAPTURE));
    assign w_wr_addr   = in_sof ? '0 : r_wr_addr;
    assign w_cap_last  = (w_wr_addr == c_AW'(c_NWORDS - 1));
    assign w_emit      = (r_state == c_S_HEADER) | (r_state == c_S_PIXELS) | (r_state == c_S_PAD);
    assign w_load      = w_emit & ~r_end & (~r_out_valid | out_ready);
    assign w_fire_last = r_out_valid & out_ready & r_out_last;
    assign w_row_end   = (r_col == c_IW'(WIDTH - 1));
    assign w_bottom    = (r_row_base == '0);
    assign w_pad_end   = (r_pad_cnt == 2'(c_PAD - 1));

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= c_S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:    if (w_store) w_next_state = w_cap_last ? c_S_HEADER : c_S_CAPTURE;
            c_S_CAPTURE: if (w_store && w_cap_last) w_next_state = c_S_HEADER;
            c_S_HEADER:  if (w_load && r_hdr_idx == 6'(HDR_BYTES - 1)) w_next_state = c_S_PIXELS;
            c_S_PIXELS: begin
                if (w_fire_last)
                    w_next_state = c_S_DONE;
                else if (w_load && r_comp == 2'd2 && w_row_end && c_PAD != 0)
                    w_next_state = c_S_PAD;
            end
            c_S_PAD: begin
                if (w_fire_last)
                    w_next_state = c_S_DONE;
                else if (w_load && w_pad_end && !w_bottom)
                    w_next_state = c_S_PIXELS;
            end
            default:     w_next_state = c_S_IDLE;
        endcase
    end

    // FSM outputs; r_alive keeps in_ready low until the first edge after reset
    always_comb begin
        in_ready   = r_alive & ((r_state == c_S_IDLE) | (r_state == c_S_CAPTURE));
        frame_done = (r_state == c_S_DONE);
    end

    // Read the next pixel in emission order while the current one's B byte goes out
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_idx = r_row_base;
        if (r_state == c_S_HEADER) begin
            w_rd_en = 1'b1;
        end else if (r_state == c_S_PIXELS && w_load && r_comp == 2'd0 && !(w_row_end && w_bottom)) begin
            w_rd_en  = 1'b1;
            w_rd_idx = w_row_end ? (r_row_base - c_IW'(WIDTH)) : (r_row_base + r_col + c_IW'(1));
        end
    end
    assign w_rd_addr = c_AW'(w_rd_idx >> c_SHIFT);

    always_ff @(posedge HCLK) begin
        if (w_store) r_mem[w_wr_addr] <= in_data;
        if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
    end

    generate
        if (PIX_PER_CLK == 2) begin : g_pp2
            logic r_rd_sel;
            always_ff @(posedge HCLK) begin
                if (w_rd_en) r_rd_sel <= w_rd_idx[0];
            end
            assign w_cur_pix = r_rd_sel ? r_rd_data[47:24] : r_rd_data[23:0];
        end else begin : g_pp1
            assign w_cur_pix = r_rd_data[23:0];
        end
    endgenerate

    always_comb begin
        w_byte = 8'h00;
        w_last = 1'b0;
        case (r_state)
            c_S_HEADER: w_byte = f_hdr_byte(r_hdr_idx);
            c_S_PIXELS: begin
                case (r_comp)
                    2'd0:    w_byte = w_cur_pix[7:0];
                    2'd1:    w_byte = r_pix[15:8];
                    default: w_byte = r_pix[23:16];
                endcase
                w_last = (r_comp == 2'd2) && w_row_end && w_bottom && (c_PAD == 0);
            end
            c_S_PAD:    w_last = w_pad_end && w_bottom;
            default:    w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_alive       <= 1'b0;
            r_sof_restart <= 1'b0;
            r_wr_addr     <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= 8'h00;
            r_out_last    <= 1'b0;
            r_end         <= 1'b0;
            r_hdr_idx     <= 6'd0;
            r_row_base    <= c_IW'((HEIGHT - 1) * WIDTH);
            r_col         <= '0;
            r_comp        <= 2'd0;
            r_pad_cnt     <= 2'd0;
            r_pix         <= 24'h0;
        end else begin
            r_alive       <= 1'b1;
            r_sof_restart <= w_store && (r_state == c_S_CAPTURE) && in_sof;
            if (w_store) r_wr_addr <= w_cap_last ? '0 : (w_wr_addr + c_AW'(1));

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_byte;
                r_out_last  <= w_last;
                if (w_last) r_end <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            if (!w_emit) begin
                r_end      <= 1'b0;
                r_hdr_idx  <= 6'd0;
                r_row_base <= c_IW'((HEIGHT - 1) * WIDTH);
                r_col      <= '0;
                r_comp     <= 2'd0;
                r_pad_cnt  <= 2'd0;
            end else if (w_load) begin
                case (r_state)
                    c_S_HEADER: r_hdr_idx <= r_hdr_idx + 6'd1;
                    c_S_PIXELS: begin
                        if (r_comp == 2'd0) begin
                            r_pix  <= w_cur_pix;
                            r_comp <= 2'd1;
                        end else if (r_comp == 2'd1) begin
                            r_comp <= 2'd2;
                        end else begin
                            r_comp <= 2'd0;
                            if (w_row_end) begin
                                r_col <= '0;
                                if (c_PAD == 0 && !w_bottom) r_row_base <= r_row_base - c_IW'(WIDTH);
                            end else begin
                                r_col <= r_col + c_IW'(1);
                            end
                        end
                    end
                    default: begin
                        if (w_pad_end) begin
                            r_pad_cnt <= 2'd0;
                            if (!w_bottom) r_row_base <= r_row_base - c_IW'(WIDTH);
                        end else begin
                            r_pad_cnt <= r_pad_cnt + 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign sof_restart = r_sof_restart;

endmodule
`default_nettype wire

// File: tb/tb_bmp_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bmp_frame_streamer                                                      |
// | Directed bench: 3x2 single-pixel and 4x2 dual-pixel BMP streamers.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_bmp_frame_streamer;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        a_in_valid, a_in_ready, a_in_sof, a_out_valid, a_out_ready;
    logic [23:0] a_in_data;
    logic [7:0]  a_out_data;
    logic        a_out_last, a_frame_done, a_sof_restart;

    logic        b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready;
    logic [47:0] b_in_data;
    logic [7:0]  b_out_data;
    logic        b_out_last, b_frame_done, b_sof_restart;

    bmp_frame_streamer #(.WIDTH(3), .HEIGHT(2), .PIX_PER_CLK(1), .HDR_BYTES(54)) u_dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .frame_done(a_frame_done), .sof_restart(a_sof_restart)
    );

    bmp_frame_streamer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_CLK(2), .HDR_BYTES(54)) u_dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .frame_done(b_frame_done), .sof_restart(b_sof_restart)
    );

    typedef struct {
        string      name;
        int         idx;
        logic [7:0] exp;
    } spot_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] q_exp[$];
    logic [7:0] q_got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [23:0] pix(input bit sel_b, input int r, input int c, input int seed);
        logic [7:0] rr, gg, bb;
        if (!sel_b) begin
            rr = 8'(16 * r + c + seed); gg = 8'(8'h80 + c); bb = 8'(8'hF0 + r);
        end else begin
            rr = 8'(16 * r + c);        gg = 8'(8'h40 + c); bb = 8'(8'hA0 + r);
        end
        return {rr, gg, bb};
    endfunction

    task automatic push_le(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) q_exp.push_back(v[8*k +: 8]);
    endtask

    // Expected byte stream built straight from the BMP layout
    task automatic build_exp(input bit sel_b, input int seed);
        int w, h, rowb, pad;
        logic [23:0] p;
        w = sel_b ? 4 : 3; h = 2;
        rowb = ((3 * w + 3) / 4) * 4; pad = rowb - 3 * w;
        q_exp.delete();
        q_exp.push_back(8'h42); q_exp.push_back(8'h4D);
        push_le(32'(54 + rowb * h), 4); push_le(0, 4); push_le(54, 4); push_le(40, 4);
        push_le(32'(w), 4); push_le(32'(h), 4); push_le(1, 2); push_le(24, 2);
        push_le(0, 4); push_le(32'(rowb * h), 4);
        for (int k = 0; k < 16; k++) q_exp.push_back(8'h00);
        for (int r = h - 1; r >= 0; r--) begin
            for (int c = 0; c < w; c++) begin
                p = pix(sel_b, r, c, seed);
                q_exp.push_back(p[7:0]); q_exp.push_back(p[15:8]); q_exp.push_back(p[23:16]);
            end
            for (int k = 0; k < pad; k++) q_exp.push_back(8'h00);
        end
    endtask

    task automatic send_a(input int seed, input int restart_at);
        int n;
        n = (restart_at >= 0) ? restart_at + 6 : 6;
        a_out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            int pi, sd;
            @(negedge HCLK);
            if (restart_at >= 0 && i == restart_at + 1) chk("sof_restart_pulse", a_sof_restart, 1);
            if (restart_at >= 0 && i == restart_at + 2) chk("sof_restart_single", a_sof_restart, 0);
            if (restart_at >= 0 && i < restart_at) begin
                pi = i; sd = 8'h55;
            end else begin
                pi = (restart_at >= 0) ? i - restart_at : i; sd = seed;
            end
            a_in_valid = 1'b1; a_in_sof = (pi == 0); a_in_data = pix(1'b0, pi / 3, pi % 3, sd);
        end
        @(negedge HCLK);
        a_in_valid = 1'b0; a_in_sof = 1'b0;
        chk("lat_in_ready_drop", a_in_ready, 0);
        chk("lat_out_valid_t1", a_out_valid, 0);
        @(negedge HCLK);
        chk("lat_out_valid_t2", a_out_valid, 1);
    endtask

    task automatic send_b();
        b_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            b_in_valid = 1'b1; b_in_sof = (i == 0);
            b_in_data  = {pix(1'b1, i / 2, 2 * (i % 2) + 1, 0), pix(1'b1, i / 2, 2 * (i % 2), 0)};
        end
        @(negedge HCLK);
        b_in_valid = 1'b0; b_in_sof = 1'b0;
        chk("b_lat_out_valid_t1", b_out_valid, 0);
        @(negedge HCLK);
        chk("b_lat_out_valid_t2", b_out_valid, 1);
    endtask

    task automatic collect(input bit sel_b, input bit rnd, input int budget);
        logic       held_v, held_l, v, l, fd, rdy;
        logic [7:0] held_d, d;
        int stall_err, last_cnt, last_pos, last_cyc, done_cyc, nmis;
        held_v = 1'b0; held_l = 1'b0; held_d = 8'h00;
        stall_err = 0; last_cnt = 0; last_pos = -1; last_cyc = -100; done_cyc = -1;
        q_got.delete();
        for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
            @(negedge HCLK);
            v  = sel_b ? b_out_valid  : a_out_valid;
            d  = sel_b ? b_out_data   : a_out_data;
            l  = sel_b ? b_out_last   : a_out_last;
            fd = sel_b ? b_frame_done : a_frame_done;
            if (fd) done_cyc = cyc;
            if (held_v && (!v || d !== held_d || l !== held_l)) stall_err++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            a_out_ready = rdy; b_out_ready = rdy;
            held_v = v && !rdy; held_d = d; held_l = l;
            if (v && rdy) begin
                q_got.push_back(d);
                if (l) begin last_cnt++; last_pos = q_got.size() - 1; last_cyc = cyc; end
            end
        end
        @(negedge HCLK);
        chk("frame_done_one_cycle", sel_b ? b_frame_done : a_frame_done, 0);
        chk("out_valid_after_done", sel_b ? b_out_valid : a_out_valid, 0);
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        chk("frame_done_seen", done_cyc >= 0, 1);
        chk("frame_done_latency", 32'(done_cyc - last_cyc), 1);
        chk("byte_count", q_got.size(), 78);
        chk("out_last_count", last_cnt, 1);
        chk("out_last_position", last_pos, 77);
        if (rnd) chk("stall_stable", stall_err, 0);
        nmis = 0;
        for (int k = 0; k < 78; k++) begin
            if (k >= q_got.size() || q_got[k] !== q_exp[k]) nmis++;
        end
        chk("stream_byte_mismatches", nmis, 0);
    endtask

    task automatic spot_check(input spot_t t[]);
        foreach (t[k]) chk(t[k].name, (t[k].idx < q_got.size()) ? {24'h0, q_got[t[k].idx]} : 32'hDEAD, {24'h0, t[k].exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        spot_t spot_a[], spot_b[];
        int    cnt;
        bit    aborted, fd_seen, rdy_err, ov_seen;

        spot_a = '{
            '{"a_hdr_B", 0, 8'h42},  '{"a_hdr_M", 1, 8'h4D},   '{"a_filesz0", 2, 8'h4E},
            '{"a_filesz1", 3, 8'h00}, '{"a_filesz3", 5, 8'h00}, '{"a_offset", 10, 8'h36},
            '{"a_dibsz", 14, 8'h28},  '{"a_width", 18, 8'h03},  '{"a_height", 22, 8'h02},
            '{"a_planes", 26, 8'h01}, '{"a_bpp", 28, 8'h18},    '{"a_imgsz", 34, 8'h18},
            '{"a_b54", 54, 8'hF1},    '{"a_g55", 55, 8'h80},    '{"a_r56", 56, 8'h10},
            '{"a_r62", 62, 8'h12},    '{"a_pad63", 63, 8'h00},  '{"a_pad65", 65, 8'h00},
            '{"a_b66", 66, 8'hF0},    '{"a_r74", 74, 8'h02}
        };
        spot_b = '{
            '{"b_filesz0", 2, 8'h4E}, '{"b_width", 18, 8'h04}, '{"b_imgsz", 34, 8'h18},
            '{"b_b54", 54, 8'hA1},    '{"b_g55", 55, 8'h40},   '{"b_r56", 56, 8'h10},
            '{"b_g58", 58, 8'h41},    '{"b_r59", 59, 8'h11},   '{"b_r65", 65, 8'h13},
            '{"b_b66", 66, 8'hA0},    '{"b_r77", 77, 8'h03}
        };

        a_in_valid = 0; a_in_sof = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_sof = 0; b_in_data = '0; b_out_ready = 0;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_frame_done", a_frame_done, 0);
        chk("rst_sof_restart", a_sof_restart, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("idle_in_ready", a_in_ready, 1);

        // Beats without in_sof in IDLE are swallowed
        rdy_err = 0; ov_seen = 0;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_in_sof = 1'b0; a_in_data = 24'($urandom);
            @(negedge HCLK);
            if (a_in_ready !== 1'b1) rdy_err = 1;
            if (a_out_valid !== 1'b0) ov_seen = 1;
        end
        a_in_valid = 1'b0;
        repeat (10) begin
            @(negedge HCLK);
            if (a_out_valid !== 1'b0) ov_seen = 1;
        end
        chk("discard_in_ready", rdy_err, 0);
        chk("discard_no_output", ov_seen, 0);

        build_exp(1'b0, 0);
        send_a(0, -1);
        collect(1'b0, 1'b0, 400);
        spot_check(spot_a);

        send_a(0, -1);
        collect(1'b0, 1'b1, 800);

        build_exp(1'b0, 8'h20);
        send_a(8'h20, 4);
        collect(1'b0, 1'b0, 400);
        chk("restart_r56", (q_got.size() > 56) ? {24'h0, q_got[56]} : 32'hDEAD, 32'h30);

        build_exp(1'b1, 0);
        send_b();
        collect(1'b1, 1'b0, 400);
        spot_check(spot_b);

        // Reset while header byte 30 is presented
        build_exp(1'b0, 0);
        send_a(0, -1);
        cnt = 0; aborted = 0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 200 && !aborted; k++) begin
            @(negedge HCLK);
            if (a_out_valid && cnt == 30) begin
                HRESETn = 1'b0;
                #1;
                chk("abort_out_valid", a_out_valid, 0);
                chk("abort_out_data", a_out_data, 0);
                aborted = 1;
            end else if (a_out_valid) begin
                cnt++;
            end
        end
        chk("abort_reached", aborted, 1);
        a_out_ready = 1'b0;
        fd_seen = 0;
        repeat (4) begin
            @(negedge HCLK);
            if (a_frame_done) fd_seen = 1;
        end
        HRESETn = 1'b1;
        repeat (10) begin
            @(negedge HCLK);
            if (a_frame_done || a_out_valid) fd_seen = 1;
        end
        chk("abort_no_frame_done", fd_seen, 0);
        send_a(0, -1);
        collect(1'b0, 1'b0, 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bmp_frame_streamer.md
Name: bmp_frame_streamer

Overview:
- Parametrised successor to the simulation-only BMP file writer.
- Captures one RGB888 frame from a valid/ready pixel stream, 1 or 2 pixels per clock, into internal frame memory.
- Then emits the complete 24-bit BMP byte stream (generated header, bottom-up rows, BGR order, 4-byte row padding) on a byte valid/ready port.
- Sits at the end of the processing pipeline and feeds a UART/DMA/file sink; it is synthesizable and has no file I/O.

Parameters:
- WIDTH, 768, image width in pixels (must be a multiple of PIX_PER_CLK).
- HEIGHT, 512, image height in rows.
- PIX_PER_CLK, 1, pixels per input beat (1 or 2).
- HDR_BYTES, 54, BMP header length (fixed at 54).

Ports:
- HCLK  input  1  clock, rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat.
- in_sof  input  1  beat carries pixel 0 of a frame.
- in_data  input  24*PIX_PER_CLK  pixel k at [24k+23:24k] as {R,G,B}; pixel 0 is leftmost.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts byte.
- out_data  output  8  BMP byte.
- out_last  output  1  final byte of file, qualified by out_valid.
- frame_done  output  1  one-cycle pulse after the final byte is accepted.
- sof_restart  output  1  one-cycle pulse when in_sof arrives mid-capture.

Behaviour:
- Reset (async, HRESETn=0): FSM=IDLE, all counters 0, in_ready=0, out_valid=0, out_data=0, out_last=0, frame_done=0, sof_restart=0. Frame memory is not cleared.
- Derived constants: ROW_BYTES = 4*ceil(3*WIDTH/4); PAD = ROW_BYTES - 3*WIDTH (0..3); IMG_BYTES = ROW_BYTES*HEIGHT; FILE_BYTES = 54 + IMG_BYTES. All are computed at elaboration as 32-bit values.
- A beat is accepted when in_valid & in_ready.
- FSM states: IDLE, CAPTURE, HEADER, PIXELS, PAD, DONE.
- IDLE:
  - in_ready=1.
  - Accepted beats without in_sof are discarded.
  - An accepted beat with in_sof is stored at pixel index 0..PIX_PER_CLK-1 -> CAPTURE (or -> HEADER if it completes the frame).
- CAPTURE:
  - in_ready=1; pixels are stored at row-major index col + row*WIDTH.
  - A beat with in_sof restarts at pixel 0 and pulses sof_restart the next cycle. The partial frame is discarded, not emitted.
  - The accepted beat that writes pixel WIDTH*HEIGHT-1 -> HEADER; in_ready drops the following cycle.
- HEADER:
  - in_ready=0; emits 54 header bytes in order, multi-byte fields little-endian:
    - 'B'(66), 'M'(77)
    - FILE_BYTES (4 bytes)
    - 0 (4 bytes)
    - 54 (4 bytes)
    - 40 (4 bytes)
    - WIDTH (4 bytes)
    - HEIGHT (4 bytes, positive, i.e. bottom-up)
    - planes=1 (2 bytes)
    - bpp=24 (2 bytes)
    - compression=0 (4 bytes)
    - IMG_BYTES (4 bytes)
    - 0 for the remaining 16 bytes
- PIXELS: rows HEIGHT-1 down to 0; within a row, pixels column 0..WIDTH-1; each pixel emitted B, G, R. At the end of a row -> PAD if PAD>0, else next row.
- PAD: emits PAD bytes of 0x00, then next row, or DONE after row 0.
- Final byte: out_last=1 on the last byte (last pixel R of row 0, or last pad byte of row 0).
- DONE: frame_done=1 for exactly one cycle -> IDLE.
- Output handshake:
  - out_data, out_last and out_valid are registered.
  - While out_valid & !out_ready, out_data and out_last hold stable.
  - A byte advances only on out_valid & out_ready.
  - With out_ready held high, a new byte is presented every cycle. The synchronous memory read is prefetched so no bubbles occur at pixel or row boundaries.
- Latency: out_valid rises 2 cycles after the last input beat is accepted. frame_done rises the cycle after the out_last byte is accepted.
- Input during emission: in_valid is ignored (in_ready=0), including any in_sof. No capture overlaps emission; the next frame requires a new in_sof after IDLE.
- Async reset mid-capture or mid-emission aborts immediately to IDLE with outputs at reset values. No partial frame_done is produced.

Test Plan:
- WIDTH=3, HEIGHT=2, PIX_PER_CLK=1, pixels p(r,c)={R=16r+c, G=0x80+c, B=0xF0+r}, out_ready=1.
  -> 78 bytes total.
  -> Bytes 2..5 = 4E 00 00 00; bytes 34..37 = 18 00 00 00.
  -> Byte 54 = B of p(1,0)=F1; bytes 63..65 = 00 00 00 (pad).
  -> out_last on byte 77; frame_done 1 cycle later.
- WIDTH=4, HEIGHT=2, PIX_PER_CLK=2 -> PAD=0, 78 bytes; pixel order within a beat is preserved (pixel 0 = bits [23:0]).
- Beats with in_sof=0 while IDLE -> in_ready=1, no capture, out_valid stays 0.
- in_sof reasserted at pixel 4 of the 3x2 frame -> sof_restart pulse; only the restarted frame is emitted (78 bytes, values from the second frame).
- Random out_ready (50% duty) on the 3x2 frame -> identical 78-byte sequence to the out_ready=1 run; out_data is stable during every stall.
- HRESETn low during byte 30 of HEADER -> out_valid=0 immediately and no frame_done. A new frame after release yields a full, correct 78-byte file.
